// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl
// Front end for the paddle stage. Raw encoder and button inputs are
// synchronised, debounced, decoded into +1/-1 step requests, merged into a
// saturating signed pending counter, and replayed to the paddle shifter as
// clean up/down pulses, each followed by an enforced low gap.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no pulse in flight; launch one as soon as pend is non-zero
// S_PULSE_UP | driving up high for PULSE_CYCLES cycles
// S_PULSE_DN | driving down high for PULSE_CYCLES cycles
// S_GAP      | both outputs low for PULSE_CYCLES cycles before the next step

module paddle_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000,
  parameter int PULSE_CYCLES    = 4,
  parameter int PEND_MAX        = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic enc_a,
  input  logic enc_b,
  input  logic btn_up,
  input  logic btn_down,
  output logic up,
  output logic down
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(RPT_MAX + 1);
  localparam int TW = $clog2(PULSE_CYCLES + 1);
  localparam int PW = $clog2(PEND_MAX + 1) + 1;
  localparam int SW = PW + 2;

  localparam logic [DW-1:0] DB_LAST       = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RPT_DLY_LOAD  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PER_LOAD  = RW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] PULSE_LOAD    = TW'(PULSE_CYCLES - 1);
  localparam logic signed [SW-1:0] ONE    = SW'(1);
  localparam logic signed [SW-1:0] PMAX_S = SW'(PEND_MAX);
  localparam logic signed [SW-1:0] PMIN_S = -PMAX_S;
  localparam logic signed [PW-1:0] PMAX_P = PW'(PEND_MAX);
  localparam logic signed [PW-1:0] PMIN_P = -PMAX_P;

  // bit positions inside the packed input vectors
  localparam int I_A  = 3;
  localparam int I_B  = 2;
  localparam int I_UP = 1;
  localparam int I_DN = 0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PULSE_UP = 2'd1,
    S_PULSE_DN = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  logic [3:0] raw;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;

  logic [3:0]    db_q, db_d;
  logic [3:0]    db_prev_q, db_prev_d;
  logic [DW-1:0] db_cnt_q [4];
  logic [DW-1:0] db_cnt_d [4];

  logic enc_step_up, enc_step_dn;

  // index 1 = up button, index 0 = down button
  logic [1:0]    rpt_act_q, rpt_act_d;
  logic [RW-1:0] rpt_tmr_q [2];
  logic [RW-1:0] rpt_tmr_d [2];
  logic [1:0]    btn_req;
  logic          both_held;

  logic signed [SW-1:0] net_req;
  logic signed [SW-1:0] consumed;
  logic signed [SW-1:0] pend_sum;
  logic signed [PW-1:0] pend_q, pend_d;
  logic                 pend_pos, pend_neg;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          up_q, up_d;
  logic          down_q, down_d;
  logic          launch_ok;

  assign raw = {enc_a, enc_b, btn_up, btn_down};

  // two-flop synchroniser on every raw input
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // debounce: count consecutive disagreeing samples, flip once the run is long enough
  always_comb begin
    db_d      = db_q;
    db_prev_d = db_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // encoder decode: only entry into detent 00 produces a step; the previous
  // debounced value doubles as the tracked state, so invalid jumps just update it
  always_comb begin
    enc_step_up = (db_q[I_A:I_B] == 2'b00) && (db_prev_q[I_A:I_B] == 2'b10);
    enc_step_dn = (db_q[I_A:I_B] == 2'b00) && (db_prev_q[I_A:I_B] == 2'b01);
  end

  // button press and auto-repeat; a held pair of buttons parks both timers
  always_comb begin
    both_held = db_q[I_UP] & db_q[I_DN];
    rpt_act_d = rpt_act_q;
    btn_req   = '0;
    for (int b = 0; b < 2; b++) begin
      rpt_tmr_d[b] = rpt_tmr_q[b];
      if (!db_q[b] || both_held) begin
        rpt_act_d[b] = 1'b0;
        rpt_tmr_d[b] = '0;
      end else if (!rpt_act_q[b]) begin
        // first held cycle: a genuine press emits, a restart after the
        // other button lets go only arms the timer
        rpt_act_d[b] = 1'b1;
        rpt_tmr_d[b] = RPT_DLY_LOAD;
        btn_req[b]   = ~db_prev_q[b];
      end else if (rpt_tmr_q[b] == '0) begin
        btn_req[b]   = 1'b1;
        rpt_tmr_d[b] = RPT_PER_LOAD;
      end else begin
        rpt_tmr_d[b] = rpt_tmr_q[b] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rpt_act_q <= '0;
      for (int b = 0; b < 2; b++) begin
        rpt_tmr_q[b] <= '0;
      end
    end else begin
      rpt_act_q <= rpt_act_d;
      for (int b = 0; b < 2; b++) begin
        rpt_tmr_q[b] <= rpt_tmr_d[b];
      end
    end
  end

  // pending counter: add net requests, remove the step the FSM just took, saturate
  always_comb begin
    net_req = '0;
    if (enc_step_up)    net_req = net_req + ONE;
    if (enc_step_dn)    net_req = net_req - ONE;
    if (btn_req[I_UP])  net_req = net_req + ONE;
    if (btn_req[I_DN])  net_req = net_req - ONE;
    pend_sum = {{(SW - PW){pend_q[PW-1]}}, pend_q} + net_req - consumed;
    if (pend_sum > PMAX_S) begin
      pend_d = PMAX_P;
    end else if (pend_sum < PMIN_S) begin
      pend_d = PMIN_P;
    end else begin
      pend_d = pend_sum[PW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // output sequencer next state; the last GAP cycle takes the same launch
  // decision IDLE would, which keeps back-to-back steps 2*PULSE_CYCLES apart
  always_comb begin
    pend_pos  = !pend_q[PW-1] && (pend_q != '0);
    pend_neg  = pend_q[PW-1];
    launch_ok = (state_q == S_IDLE) || ((state_q == S_GAP) && (tmr_q == '0));
    state_d   = state_q;
    tmr_d     = tmr_q;
    consumed  = '0;
    if (launch_ok) begin
      if (pend_pos) begin
        state_d  = S_PULSE_UP;
        tmr_d    = PULSE_LOAD;
        consumed = ONE;
      end else if (pend_neg) begin
        state_d  = S_PULSE_DN;
        tmr_d    = PULSE_LOAD;
        consumed = -ONE;
      end else begin
        state_d  = S_IDLE;
        tmr_d    = '0;
      end
    end else begin
      case (state_q)
        S_PULSE_UP, S_PULSE_DN: begin
          if (tmr_q == '0) begin
            state_d = S_GAP;
            tmr_d   = PULSE_LOAD;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        S_GAP: begin
          tmr_d = tmr_q - 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end
      endcase
    end
    up_d   = (state_d == S_PULSE_UP);
    down_d = (state_d == S_PULSE_DN);
  end

  // output sequencer state, pulse timer and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      up_q    <= up_d;
      down_q  <= down_d;
    end
  end

  assign up   = up_q;
  assign down = down_q;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Self-checking bench for paddle_input_ctrl. Expected pulses are queued with
// their direction and (when known) the exact edge at which they must rise;
// a monitor pops and checks them, plus width, gap and overlap rules.
// A second instance with long pulses lets requests outrun the output so the
// pending counter saturates.

module tb_paddle_input_ctrl;

  localparam int DBC    = 4;
  localparam int RD     = 20;
  localparam int RP     = 10;
  localparam int PC     = 2;
  localparam int PM     = 3;
  localparam int PC_SAT = 16;
  localparam int LAT    = 8;   // raw change to output rise: 2 sync + 4 debounce + 2

  logic clk = 1'b0;
  logic reset;
  logic enc_a, enc_b, btn_up, btn_down, up, down;
  logic s_enc_a, s_enc_b, s_btn_up, s_btn_down, s_up, s_down;

  paddle_input_ctrl #(
    .DEBOUNCE_CYCLES(DBC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .PULSE_CYCLES(PC), .PEND_MAX(PM)
  ) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .btn_up(btn_up), .btn_down(btn_down), .up(up), .down(down)
  );

  paddle_input_ctrl #(
    .DEBOUNCE_CYCLES(DBC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .PULSE_CYCLES(PC_SAT), .PEND_MAX(PM)
  ) dut_sat (
    .clk(clk), .reset(reset), .enc_a(s_enc_a), .enc_b(s_enc_b),
    .btn_up(s_btn_up), .btn_down(s_btn_down), .up(s_up), .down(s_down)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int lim);
    n_checks++;
    if (act < lim) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected at least %0d (cycle %0d)", name, act, lim, cyc);
    end
  endtask

  typedef struct {
    logic dir;   // 1 = up, 0 = down
    int   at;    // edge index of the rise, -1 when not pinned
  } sb_t;
  sb_t sb[$];

  task automatic push(input logic dir, input int at);
    sb_t x;
    x.dir = dir;
    x.at  = at;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // ---------------- main-instance monitor ----------------
  int   n_up = 0, n_dn = 0;
  int   hi_len = 0, lo_len = 0;
  logic have_fall = 1'b0;
  logic up_p = 1'b0, dn_p = 1'b0;
  sb_t  got;

  always @(posedge clk) begin
    #1;
    check_eq("no_overlap", int'(up === 1'b1 && down === 1'b1), 0);
    if ((up && !up_p) || (down && !dn_p)) begin
      if (have_fall) check_ge("low_gap", lo_len, PC);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got %s pulse at cycle %0d, expected none",
                 up ? "up" : "down", cyc);
      end else begin
        got = sb.pop_front();
        check_eq("pulse_dir", int'(up), int'(got.dir));
        if (got.at >= 0) check_eq("pulse_time", cyc, got.at);
      end
      if (up) n_up++;
      else    n_dn++;
      hi_len = 1;
    end else if (up || down) begin
      hi_len++;
    end else if (up_p || dn_p) begin
      check_eq("pulse_width", hi_len, PC);
      have_fall = 1'b1;
      lo_len    = 1;
    end else begin
      lo_len++;
    end
    up_p = up;
    dn_p = down;
  end

  // ---------------- saturation-instance monitor ----------------
  int   s_n_up = 0, s_n_dn = 0;
  logic s_up_p = 1'b0, s_dn_p = 1'b0;

  always @(posedge clk) begin
    #1;
    if (s_up === 1'b1 && s_down === 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL sat_overlap: got up=1 down=1 at cycle %0d, expected never both", cyc);
    end
    if (s_up && !s_up_p) s_n_up++;
    if (s_down && !s_dn_p) s_n_dn++;
    s_up_p = s_up;
    s_dn_p = s_down;
  end

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      tick(1);
      t++;
    end
    tick(10);
    check_eq({name, "_drain"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // encoder stimulus table: {a,b}, hold cycles, expected step (+1/-1/0)
  typedef struct {
    logic [1:0] ab;
    int         hold;
    int         step;
  } enc_vec_t;

  enc_vec_t ev[22];

  initial begin
    int k, b_up, b_dn, e_up, e_dn;

    // three forward detents
    for (int r = 0; r < 3; r++) begin
      ev[r*4 + 0] = '{2'b01, 5, 0};
      ev[r*4 + 1] = '{2'b11, 5, 0};
      ev[r*4 + 2] = '{2'b10, 5, 0};
      ev[r*4 + 3] = '{2'b00, 5, 1};
    end
    ev[12] = '{2'b10, 5, 0};
    ev[13] = '{2'b00, 5, 1};     // short forward detent
    ev[14] = '{2'b01, 5, 0};
    ev[15] = '{2'b00, 5, -1};    // short backward detent
    ev[16] = '{2'b11, 5, 0};     // invalid double-bit jump out of detent
    ev[17] = '{2'b00, 5, 0};     // invalid double-bit jump back in: ignored
    ev[18] = '{2'b01, 5, 0};
    ev[19] = '{2'b11, 5, 0};
    ev[20] = '{2'b01, 5, 0};     // rocks back before reaching detent
    ev[21] = '{2'b00, 5, -1};

    reset = 1'b0;
    {enc_a, enc_b, btn_up, btn_down} = '0;
    {s_enc_a, s_enc_b, s_btn_up, s_btn_down} = '0;

    // 1: outputs stay low under reset while inputs thrash, and stay low after
    for (int i = 0; i < 5; i++) begin
      {enc_a, enc_b, btn_up, btn_down} = 4'($urandom);
      tick(1);
      check_eq("reset_up", int'(up), 0);
      check_eq("reset_down", int'(down), 0);
    end
    {enc_a, enc_b, btn_up, btn_down} = '0;
    tick(1);
    reset = 1'b1;
    b_up = n_up; b_dn = n_dn;
    tick(100);
    check_eq("idle_up_count", n_up - b_up, 0);
    check_eq("idle_down_count", n_dn - b_dn, 0);

    // encoder table
    b_up = n_up; b_dn = n_dn; e_up = 0; e_dn = 0;
    for (int i = 0; i < 22; i++) begin
      enc_a = ev[i].ab[1];
      enc_b = ev[i].ab[0];
      k = cyc;
      if (ev[i].step > 0) begin
        push(1'b1, k + LAT);
        e_up++;
      end else if (ev[i].step < 0) begin
        push(1'b0, k + LAT);
        e_dn++;
      end
      tick(ev[i].hold);
    end
    drain("enc_table");
    check_eq("enc_up_count", n_up - b_up, e_up);
    check_eq("enc_down_count", n_dn - b_dn, e_dn);

    // 2: bouncy press and release, one up pulse two cycles after the debounced edge
    b_up = n_up; b_dn = n_dn;
    btn_up = 1'b1; tick(1);
    btn_up = 1'b0; tick(1);
    btn_up = 1'b1;
    k = cyc;
    push(1'b1, k + LAT);
    tick(15);
    btn_up = 1'b0; tick(1);
    btn_up = 1'b1; tick(1);
    btn_up = 1'b0;
    tick(20);
    drain("bounce");
    check_eq("bounce_up_count", n_up - b_up, 1);
    check_eq("bounce_down_count", n_dn - b_dn, 0);

    // 3: held button auto-repeats at offsets 0, 20, 30, 40, 50
    b_up = n_up; b_dn = n_dn;
    btn_up = 1'b1;
    k = cyc;
    push(1'b1, k + LAT);
    push(1'b1, k + LAT + RD);
    push(1'b1, k + LAT + RD + RP);
    push(1'b1, k + LAT + RD + 2*RP);
    push(1'b1, k + LAT + RD + 3*RP);
    tick(56);
    btn_up = 1'b0;
    tick(30);
    drain("repeat");
    check_eq("repeat_up_count", n_up - b_up, 5);
    check_eq("repeat_down_count", n_dn - b_dn, 0);

    // 4: six fast down detents into a slow output saturate pend at -3;
    // one step is consumed on entry, three queue, one more is served
    // before the sixth arrives, so the sixth is dropped
    b_up = s_n_up; b_dn = s_n_dn;
    for (int i = 0; i < 6; i++) begin
      s_enc_a = 1'b0; s_enc_b = 1'b1;
      tick(5);
      s_enc_a = 1'b0; s_enc_b = 1'b0;
      tick(5);
    end
    tick(200);
    check_eq("sat_down_count", s_n_dn - b_dn, 5);
    check_eq("sat_up_count", s_n_up - b_up, 0);

    // 5a: both buttons held -> nothing; releasing down restarts up's timer without a press step
    b_up = n_up; b_dn = n_dn;
    btn_up = 1'b1; btn_down = 1'b1;
    k = cyc;
    tick(40);
    check_eq("both_held_up", n_up - b_up, 0);
    check_eq("both_held_down", n_dn - b_dn, 0);
    btn_down = 1'b0;
    push(1'b1, k + 40 + 6 + RD + 2);
    tick(28);
    btn_up = 1'b0;
    tick(30);
    drain("both_release");
    check_eq("restart_up_count", n_up - b_up, 1);
    check_eq("restart_down_count", n_dn - b_dn, 0);

    // 5b: encoder up detent and down press on the same debounced edge cancel
    enc_a = 1'b1; enc_b = 1'b0;
    tick(8);
    b_up = n_up; b_dn = n_dn;
    enc_a = 1'b0; enc_b = 1'b0; btn_down = 1'b1;
    tick(10);
    btn_down = 1'b0;
    tick(40);
    check_eq("cancel_up_count", n_up - b_up, 0);
    check_eq("cancel_down_count", n_dn - b_dn, 0);

    // 6: reset in the second PULSE_UP cycle with another step still pending
    enc_a = 1'b1; enc_b = 1'b0;
    tick(8);
    b_up = n_up; b_dn = n_dn;
    enc_a = 1'b0; enc_b = 1'b0; btn_up = 1'b1;
    k = cyc;
    push(1'b1, k + LAT);
    tick(LAT + 1);
    reset = 1'b0;
    btn_up = 1'b0;
    tick(1);
    check_eq("abort_up", int'(up), 0);
    check_eq("abort_down", int'(down), 0);
    tick(3);
    reset = 1'b1;
    tick(60);
    check_eq("abort_up_count", n_up - b_up, 1);
    check_eq("abort_down_count", n_dn - b_dn, 0);
    check_eq("final_queue", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
